// File: rtl/spi_master_pkg.sv
// Shared SPI types: slave select encoding, word size and the active-low select decode.
package spi_master_pkg;

  typedef enum logic [2:0] {
    SS_NONE    = 3'd0,
    SS_CH1     = 3'd1,
    SS_CH2     = 3'd2,
    SS_CH3     = 3'd3,
    SS_TRIGGER = 3'd4,
    SS_EEPROM  = 3'd5
  } SlaveSelect;

  localparam int unsigned SPI_BITS = 16;
  localparam int unsigned NUM_SS   = 5;
  localparam int unsigned EEP_W    = 8;
  localparam int unsigned BCNT_W   = $clog2(SPI_BITS + 1);

  // SS_NONE and unused encodings assert no line; the transfer still runs as a spacer.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [2:0] sel);
    logic [NUM_SS-1:0] lines;
    lines = '1;
    case (sel)
      SS_CH1:     lines[0] = 1'b0;
      SS_CH2:     lines[1] = 1'b0;
      SS_CH3:     lines[2] = 1'b0;
      SS_TRIGGER: lines[3] = 1'b0;
      SS_EEPROM:  lines[4] = 1'b0;
      default:    lines = '1;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/spi_master_sclk_gen.sv
// SCLK divider: toggles SCLK every HALF clocks and flags the last cycle of each half.
module spi_sclk_gen #(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold_low,
  output logic sclk,
  output logic fall,
  output logic phase_end
);

  localparam int unsigned HALF  = SCLK_DIV / 2;
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sclk_nxt;

  // hold_low keeps SCLK parked low once the final bit has been clocked
  always_comb begin
    cnt_nxt  = cnt + CNT_W'(1);
    sclk_nxt = sclk;
    if (clr) begin
      cnt_nxt  = '0;
      sclk_nxt = 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt  = '0;
      sclk_nxt = ~sclk & ~hold_low;
    end
  end

  // Strobes are registered from the next-state so they coincide with the last cycle of a half
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sclk      <= 1'b0;
      fall      <= 1'b0;
      phase_end <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      sclk      <= sclk_nxt;
      fall      <= ~clr & sclk_nxt & (cnt_nxt == CNT_LAST);
      phase_end <= ~clr & ~sclk_nxt & (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 transaction engine: shifts a 16-bit word out MSB first, captures the reply,
// drives per-slave active-low selects and returns the received low byte.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrt_SPI,
  input  SlaveSelect          ss,
  input  logic [SPI_BITS-1:0] SPI_data,
  output logic                SPI_done,
  output logic [EEP_W-1:0]    EEP_data,
  output logic                busy,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO,
  output logic [NUM_SS-1:0]   SS_n
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRONT = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [SPI_BITS-1:0] shreg;
  logic [SPI_BITS-1:0] shreg_nxt;
  SlaveSelect          ss_q;
  SlaveSelect          ss_nxt;
  logic [BCNT_W-1:0]   bitcnt;
  logic [BCNT_W-1:0]   bitcnt_nxt;
  logic                done_nxt;
  logic [EEP_W-1:0]    eep_nxt;
  logic                busy_nxt;
  logic                mosi_nxt;
  logic [NUM_SS-1:0]   ss_n_nxt;

  logic gen_clr;
  logic last_bit;
  logic fall;
  logic phase_end;

  assign gen_clr  = (state == IDLE);
  assign last_bit = (bitcnt == BCNT_W'(SPI_BITS));

  spi_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (gen_clr),
    .hold_low  (last_bit),
    .sclk      (SCLK),
    .fall      (fall),
    .phase_end (phase_end)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    ss_nxt     = ss_q;
    bitcnt_nxt = bitcnt;
    done_nxt   = 1'b0;
    eep_nxt    = EEP_data;
    case (state)
      IDLE: begin
        if (wrt_SPI) begin
          state_nxt  = FRONT;
          shreg_nxt  = SPI_data;
          ss_nxt     = ss;
          bitcnt_nxt = '0;
        end
      end
      FRONT: begin
        if (phase_end) state_nxt = SHIFT;
      end
      SHIFT: begin
        // MISO is captured on the falling-edge clock, before the slave updates it
        if (fall) begin
          shreg_nxt  = {shreg[SPI_BITS-2:0], MISO};
          bitcnt_nxt = bitcnt + BCNT_W'(1);
        end
        if (phase_end && last_bit) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          eep_nxt   = shreg[EEP_W-1:0];
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
    mosi_nxt = busy_nxt & shreg_nxt[SPI_BITS-1];
    ss_n_nxt = busy_nxt ? ss_decode(ss_nxt) : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      ss_q     <= SS_NONE;
      bitcnt   <= '0;
      SPI_done <= 1'b0;
      EEP_data <= '0;
      busy     <= 1'b0;
      MOSI     <= 1'b0;
      SS_n     <= '1;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      ss_q     <= ss_nxt;
      bitcnt   <= bitcnt_nxt;
      SPI_done <= done_nxt;
      EEP_data <= eep_nxt;
      busy     <= busy_nxt;
      MOSI     <= mosi_nxt;
      SS_n     <= ss_n_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: timing, select decode, reply capture, ignore and abort cases.
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int unsigned DIV        = 32;
  localparam int unsigned HALF       = DIV / 2;
  localparam int unsigned SS_LOW_CYC = 16 * DIV + HALF;
  localparam int unsigned DONE_CYC   = SS_LOW_CYC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrt_SPI;
  SlaveSelect  ss;
  logic [15:0] SPI_data;
  logic        SPI_done;
  logic [7:0]  EEP_data;
  logic        busy;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [4:0]  SS_n;

  logic [15:0] slave_sh;
  int          n_checks;
  int          n_errors;

  int          o_done_cyc;
  int          o_n_done;
  int          o_n_rise;
  int          o_first_rise;
  int          o_ssn_ok;
  int          o_busy_cyc;
  logic [15:0] o_mosi;
  logic [7:0]  o_eep;
  logic [4:0]  o_ssn_at_done;

  spi_master #(.SCLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .wrt_SPI  (wrt_SPI),
    .ss       (ss),
    .SPI_data (SPI_data),
    .SPI_done (SPI_done),
    .EEP_data (EEP_data),
    .busy     (busy),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .SS_n     (SS_n)
  );

  always #5 clk = ~clk;

  assign MISO = slave_sh[15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents the accept strobe and loads the slave reply
  task automatic start(input SlaveSelect s, input logic [15:0] d, input logic [15:0] rsp);
    wrt_SPI  = 1'b1;
    ss       = s;
    SPI_data = d;
    slave_sh = rsp;
  endtask

  // Samples cycles 1..limit after the accept; the slave shifts its reply after each SCLK fall
  task automatic observe(input int limit, input logic [4:0] exp_ssn, input bit stop_on_done,
                         input int inj_c, input int rst_c);
    logic prev;
    prev = 1'b0;
    o_done_cyc = 0; o_n_done = 0; o_n_rise = 0; o_first_rise = 0;
    o_ssn_ok = 0; o_busy_cyc = 0; o_mosi = '0; o_eep = '0; o_ssn_at_done = '0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) wrt_SPI = 1'b0;
      if (SCLK && !prev) begin
        o_n_rise++;
        if (o_n_rise == 1) o_first_rise = c;
        o_mosi = {o_mosi[14:0], MOSI};
      end
      if (!SCLK && prev) slave_sh = {slave_sh[14:0], 1'b0};
      prev = SCLK;
      if (c <= int'(SS_LOW_CYC) && SS_n == exp_ssn) o_ssn_ok++;
      if (busy) o_busy_cyc++;
      if (SPI_done) begin
        o_n_done++;
        if (o_n_done == 1) begin
          o_done_cyc    = c;
          o_eep         = EEP_data;
          o_ssn_at_done = SS_n;
        end
      end
      if (c == inj_c) begin
        wrt_SPI  = 1'b1;
        SPI_data = 16'hFFFF;
        ss       = SS_CH1;
      end
      if (c == inj_c + 1) wrt_SPI = 1'b0;
      if (c == rst_c) rst = 1'b1;
      if (c == rst_c + 1) begin
        rst = 1'b0;
        check("abort_sclk", 32'(SCLK), 32'h0);
        check("abort_ssn", 32'(SS_n), 32'h1F);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(SPI_done), 32'h0);
        check("abort_eep", 32'(EEP_data), 32'h0);
      end
      if (stop_on_done && SPI_done) break;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    wrt_SPI  = 1'b0;
    ss       = SS_NONE;
    SPI_data = '0;
    slave_sh = '0;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(SCLK), 32'h0);
    check("rst_mosi", 32'(MOSI), 32'h0);
    check("rst_ssn", 32'(SS_n), 32'h1F);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(SPI_done), 32'h0);
    check("rst_eep", 32'(EEP_data), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // EEPROM write, MISO held low
    start(SS_EEPROM, 16'h4A5C, 16'h0000);
    observe(600, 5'h0F, 1'b0, -1, -1);
    check("t1_ssn_low", 32'(o_ssn_ok), 32'(SS_LOW_CYC));
    check("t1_rises", 32'(o_n_rise), 32'd16);
    check("t1_first_rise", 32'(o_first_rise), 32'(HALF + 1));
    check("t1_mosi", 32'(o_mosi), 32'h4A5C);
    check("t1_done_cyc", 32'(o_done_cyc), 32'(DONE_CYC));
    check("t1_n_done", 32'(o_n_done), 32'd1);
    check("t1_eep", 32'(o_eep), 32'h00);
    check("t1_busy_cyc", 32'(o_busy_cyc), 32'(SS_LOW_CYC));
    check("t1_ssn_done", 32'(o_ssn_at_done), 32'h1F);

    // Reply capture and hold
    start(SS_CH1, 16'h1234, 16'h00C3);
    observe(560, 5'h1E, 1'b0, -1, -1);
    check("t2_ssn_low", 32'(o_ssn_ok), 32'(SS_LOW_CYC));
    check("t2_eep", 32'(o_eep), 32'hC3);
    check("t2_eep_held", 32'(EEP_data), 32'hC3);

    // Dispatcher read: spacer then EEPROM, chained on SPI_done
    start(SS_NONE, 16'h0300, 16'h0000);
    observe(600, 5'h1F, 1'b1, -1, -1);
    check("t3a_ssn_high", 32'(o_ssn_ok), 32'(SS_LOW_CYC));
    check("t3a_rises", 32'(o_n_rise), 32'd16);
    check("t3a_done_cyc", 32'(o_done_cyc), 32'(DONE_CYC));
    check("t3a_ssn_done", 32'(o_ssn_at_done), 32'h1F);
    start(SS_EEPROM, 16'h0300, 16'hA55A);
    observe(600, 5'h0F, 1'b1, -1, -1);
    check("t3b_ssn_low", 32'(o_ssn_ok), 32'(SS_LOW_CYC));
    check("t3b_done_cyc", 32'(o_done_cyc), 32'(DONE_CYC));
    check("t3b_eep", 32'(o_eep), 32'h5A);
    check("t3b_mosi", 32'(o_mosi), 32'h0300);
    @(negedge clk);

    // Strobe mid-transfer must be ignored
    start(SS_CH2, 16'h8001, 16'h1234);
    observe(600, 5'h1D, 1'b0, 100, -1);
    check("t4_mosi", 32'(o_mosi), 32'h8001);
    check("t4_n_done", 32'(o_n_done), 32'd1);
    check("t4_done_cyc", 32'(o_done_cyc), 32'(DONE_CYC));
    check("t4_ssn_low", 32'(o_ssn_ok), 32'(SS_LOW_CYC));
    check("t4_eep", 32'(o_eep), 32'h34);

    // Reset in cycle 200 aborts without a done pulse
    start(SS_EEPROM, 16'hBEEF, 16'hFFFF);
    observe(600, 5'h0F, 1'b0, -1, 200);
    check("t5_n_done", 32'(o_n_done), 32'd0);
    check("t5_busy_cyc", 32'(o_busy_cyc), 32'd200);
    start(SS_CH3, 16'h0F0F, 16'h5555);
    observe(600, 5'h1B, 1'b0, -1, -1);
    check("t5b_ssn_low", 32'(o_ssn_ok), 32'(SS_LOW_CYC));
    check("t5b_done_cyc", 32'(o_done_cyc), 32'(DONE_CYC));
    check("t5b_n_done", 32'(o_n_done), 32'd1);
    check("t5b_eep", 32'(o_eep), 32'h55);
    check("t5b_mosi", 32'(o_mosi), 32'h0F0F);

    // Unused encoding 7 selects nothing but keeps full timing
    start(SlaveSelect'(3'd7), 16'hC001, 16'h0000);
    observe(600, 5'h1F, 1'b0, -1, -1);
    check("t6_ssn_high", 32'(o_ssn_ok), 32'(SS_LOW_CYC));
    check("t6_rises", 32'(o_n_rise), 32'd16);
    check("t6_done_cyc", 32'(o_done_cyc), 32'(DONE_CYC));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
